pipelined_decoder: RTL and testbench

PIPELINED_DECODER -- requirements
Module: pipelined_decoder

---
 rtl/decoder_pkg.sv | 83 ++++++++
 rtl/decode_fields.sv | 179 +++++++++++++++++
 rtl/pipelined_decoder.sv | 161 ++++++++++++++++
 tb/tb_pipelined_decoder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared types for the pipelined RV32 decoder: opcode and funct7
//               constants, ALU-operation and write-back-select encodings, the
//               two-entry buffer state encoding and the decoded-fields record.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   // funct7 values that select base, alternate (SUB/SRA) and multiply/divide
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // ALU operand-B select
   localparam logic [1:0] ALU_SRC_RS2 = 2'b00;
   localparam logic [1:0] ALU_SRC_IMM = 2'b01;

   // Base ALU operations; bit 4 is reserved for the multiply/divide group,
   // which is encoded as {1'b1, 1'b0, funct3} and so has no enum member.
   typedef enum logic [4:0] {
      ALU_ADD  = 5'b00000,
      ALU_SUB  = 5'b00001,
      ALU_AND  = 5'b00010,
      ALU_OR   = 5'b00011,
      ALU_XOR  = 5'b00100,
      ALU_SLL  = 5'b00101,
      ALU_SRL  = 5'b00110,
      ALU_SRA  = 5'b00111,
      ALU_SLT  = 5'b01000,
      ALU_SLTU = 5'b01001
   } alu_op_e;

   // Write-back source select
   typedef enum logic [1:0] {
      MTR_ALU    = 2'b00,   // ALU result (LUI passes the immediate through)
      MTR_PC_IMM = 2'b01,   // pc + imm (AUIPC)
      MTR_PC4    = 2'b10,   // pc + 4 (link address for JAL/JALR)
      MTR_MEM    = 2'b11    // load data
   } mem_to_reg_e;

   // Occupancy of the output + skid buffer pair
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_TWO   = 2'b10
   } state_e;

   // Decoded instruction. imm is kept at 32 bits: every RV32 immediate is
   // already sign-extended from instr[31] at that width, so widening to XLEN
   // is a plain replication of bit 31 done at the output.
   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [31:0] imm;
      logic [4:0]  alu_op;
      logic [1:0]  alu_src;
      mem_to_reg_e mem_to_reg;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        illegal;
   } dec_fields_t;

endpackage
`default_nettype wire

// File: rtl/decode_fields.sv
`default_nettype none
// ============================================================================
// Module      : decode_fields
// Description : Purely combinational RV32I (+ optional RV32M) instruction
//               decoder producing the decoded-fields record.
// Parameters  : ENABLE_M - nonzero accepts RV32M in OP; zero flags it illegal
// Ports       : instr  in  [31:0]  raw instruction word
//               fields out          decoded record (dec_fields_t)
// Revision    : 1.0 - initial release
// ============================================================================
module decode_fields
   import decoder_pkg::*;
#(
   parameter int ENABLE_M = 0
) (
   input  logic [31:0] instr,
   output dec_fields_t fields
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;
   dec_fields_t dec;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   always_comb begin
      dec            = '0;
      dec.rs1        = instr[19:15];
      dec.rs2        = instr[24:20];
      dec.rd         = instr[11:7];
      dec.funct3     = funct3;
      dec.alu_op     = ALU_ADD;
      dec.alu_src    = ALU_SRC_RS2;
      dec.mem_to_reg = MTR_ALU;

      case (opcode)
         OPC_OP: begin
            dec.reg_write = 1'b1;
            if (funct7 == F7_BASE) begin
               case (funct3)
                  3'b000:  dec.alu_op = ALU_ADD;
                  3'b001:  dec.alu_op = ALU_SLL;
                  3'b010:  dec.alu_op = ALU_SLT;
                  3'b011:  dec.alu_op = ALU_SLTU;
                  3'b100:  dec.alu_op = ALU_XOR;
                  3'b101:  dec.alu_op = ALU_SRL;
                  3'b110:  dec.alu_op = ALU_OR;
                  default: dec.alu_op = ALU_AND;
               endcase
            end else if (funct7 == F7_ALT) begin
               // Only SUB and SRA exist in the alternate encoding space
               if (funct3 == 3'b000)      dec.alu_op  = ALU_SUB;
               else if (funct3 == 3'b101) dec.alu_op  = ALU_SRA;
               else                       dec.illegal = 1'b1;
            end else if ((ENABLE_M != 0) && (funct7 == F7_MULDIV)) begin
               dec.alu_op = {2'b10, funct3};
            end else begin
               dec.illegal = 1'b1;
            end
         end

         OPC_OP_IMM: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = ALU_SRC_IMM;
            dec.imm       = imm_i;
            case (funct3)
               3'b000: dec.alu_op = ALU_ADD;
               3'b010: dec.alu_op = ALU_SLT;
               3'b011: dec.alu_op = ALU_SLTU;
               3'b100: dec.alu_op = ALU_XOR;
               3'b110: dec.alu_op = ALU_OR;
               3'b001: begin
                  dec.alu_op = ALU_SLL;
                  if (funct7 != F7_BASE) dec.illegal = 1'b1;
               end
               3'b101: begin
                  // instr[30] picks arithmetic vs logical right shift
                  if (instr[30]) begin
                     dec.alu_op = ALU_SRA;
                     if (funct7 != F7_ALT) dec.illegal = 1'b1;
                  end else begin
                     dec.alu_op = ALU_SRL;
                     if (funct7 != F7_BASE) dec.illegal = 1'b1;
                  end
               end
               default: dec.alu_op = ALU_AND;
            endcase
         end

         OPC_LOAD: begin
            dec.reg_write  = 1'b1;
            dec.mem_read   = 1'b1;
            dec.mem_to_reg = MTR_MEM;
            dec.alu_src    = ALU_SRC_IMM;
            dec.imm        = imm_i;
         end

         OPC_STORE: begin
            dec.mem_write = 1'b1;
            dec.alu_src   = ALU_SRC_IMM;
            dec.imm       = imm_s;
         end

         OPC_BRANCH: begin
            dec.branch = 1'b1;
            dec.alu_op = ALU_SUB;
            dec.imm    = imm_b;
         end

         OPC_AUIPC: begin
            dec.reg_write  = 1'b1;
            dec.mem_to_reg = MTR_PC_IMM;
            dec.alu_src    = ALU_SRC_IMM;
            dec.imm        = imm_u;
         end

         OPC_LUI: begin
            dec.reg_write  = 1'b1;
            dec.mem_to_reg = MTR_ALU;
            dec.alu_src    = ALU_SRC_IMM;
            dec.imm        = imm_u;
         end

         OPC_JAL: begin
            dec.reg_write  = 1'b1;
            dec.jump       = 1'b1;
            dec.mem_to_reg = MTR_PC4;
            dec.alu_src    = ALU_SRC_IMM;
            dec.imm        = imm_j;
         end

         OPC_JALR: begin
            dec.reg_write  = 1'b1;
            dec.jump       = 1'b1;
            dec.mem_to_reg = MTR_PC4;
            dec.alu_src    = ALU_SRC_IMM;
            dec.imm        = imm_i;
            if (funct3 != 3'b000) dec.illegal = 1'b1;
         end

         default: dec.illegal = 1'b1;
      endcase

      // Compressed / non-32-bit encodings are not supported
      if (instr[1:0] != 2'b11) dec.illegal = 1'b1;

      // x0 is hard-wired to zero, so a write to it is suppressed here rather
      // than relying on the register file to ignore it.
      if (dec.rd == 5'd0) dec.reg_write = 1'b0;

      // Illegal entries still flow down the pipe (so a trap can be raised in
      // order) but must not cause any architectural side effect.
      if (dec.illegal) begin
         dec.reg_write = 1'b0;
         dec.mem_read  = 1'b0;
         dec.mem_write = 1'b0;
         dec.branch    = 1'b0;
         dec.jump      = 1'b0;
      end
   end

   assign fields = dec;

endmodule
`default_nettype wire

// File: rtl/pipelined_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_decoder
// Description : One-stage registered RV32 decoder with a two-entry (output +
//               skid) buffer so that in_ready never depends combinationally
//               on out_ready.
// Parameters  : XLEN     - width of pc and immediate (32 or 64)
//               ENABLE_M - nonzero enables RV32M decode
// Ports       : clk, rst (async, active high)
//               in_valid/in_ready, in_instr[31:0], in_pc[XLEN-1:0]
//               flush     - drops held and incoming instructions
//               out_valid/out_ready, out_pc, out_rs1/rs2/rd, out_funct3,
//               out_imm, out_alu_op, out_alu_src, out_mem_to_reg,
//               out_reg_write, out_mem_read, out_mem_write, out_branch,
//               out_jump, out_illegal
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_decoder
   import decoder_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ENABLE_M = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [2:0]      out_funct3,
   output logic [XLEN-1:0] out_imm,
   output logic [4:0]      out_alu_op,
   output logic [1:0]      out_alu_src,
   output logic [1:0]      out_mem_to_reg,
   output logic            out_reg_write,
   output logic            out_mem_read,
   output logic            out_mem_write,
   output logic            out_branch,
   output logic            out_jump,
   output logic            out_illegal
);

   state_e          state_q,    state_d;
   logic            in_ready_q, in_ready_d;
   dec_fields_t     out_q,      out_d;
   logic [XLEN-1:0] out_pc_q,   out_pc_d;
   dec_fields_t     skid_q,     skid_d;
   logic [XLEN-1:0] skid_pc_q,  skid_pc_d;

   dec_fields_t     in_fields;
   logic            in_xfer;
   logic            out_xfer;

   decode_fields #(
      .ENABLE_M (ENABLE_M)
   ) u_decode_fields (
      .instr  (in_instr),
      .fields (in_fields)
   );

   assign out_valid = (state_q != ST_EMPTY);
   assign in_xfer   = in_valid && in_ready_q;
   assign out_xfer  = out_valid && out_ready;

   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      out_pc_d  = out_pc_q;
      skid_d    = skid_q;
      skid_pc_d = skid_pc_q;

      case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               out_d    = in_fields;
               out_pc_d = in_pc;
               state_d  = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_xfer && !out_xfer) begin
               // Output is stalled: park the newcomer behind it
               skid_d    = in_fields;
               skid_pc_d = in_pc;
               state_d   = ST_TWO;
            end else if (in_xfer && out_xfer) begin
               out_d    = in_fields;
               out_pc_d = in_pc;
            end else if (out_xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            // in_ready is low here, so only the drain side can move
            if (out_xfer) begin
               out_d    = skid_q;
               out_pc_d = skid_pc_q;
               state_d  = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      if (flush) state_d = ST_EMPTY;

      // Registered ready: computed from the next occupancy so it is valid
      // the cycle after, and stays low through reset until the first edge.
      in_ready_d = (state_d != ST_TWO);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b0;
         out_q      <= '0;
         out_pc_q   <= '0;
         skid_q     <= '0;
         skid_pc_q  <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         out_q      <= out_d;
         out_pc_q   <= out_pc_d;
         skid_q     <= skid_d;
         skid_pc_q  <= skid_pc_d;
      end
   end

   generate
      if (XLEN > 32) begin : g_imm_wide
         assign out_imm = {{(XLEN-32){out_q.imm[31]}}, out_q.imm};
      end else begin : g_imm_narrow
         assign out_imm = out_q.imm[XLEN-1:0];
      end
   endgenerate

   assign in_ready       = in_ready_q;
   assign out_pc         = out_pc_q;
   assign out_rs1        = out_q.rs1;
   assign out_rs2        = out_q.rs2;
   assign out_rd         = out_q.rd;
   assign out_funct3     = out_q.funct3;
   assign out_alu_op     = out_q.alu_op;
   assign out_alu_src    = out_q.alu_src;
   assign out_mem_to_reg = out_q.mem_to_reg;
   assign out_reg_write  = out_q.reg_write;
   assign out_mem_read   = out_q.mem_read;
   assign out_mem_write  = out_q.mem_write;
   assign out_branch     = out_q.branch;
   assign out_jump       = out_q.jump;
   assign out_illegal    = out_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_decoder
// Description : Directed self-checking bench for pipelined_decoder. Two
//               instances share stimulus: one with RV32M disabled, one with
//               it enabled. Expected records are queued on input acceptance
//               and compared when each instance transfers an output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_decoder;

   localparam int XLEN = 32;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [4:0]  alu_op;
      logic [1:0]  alu_src;
      logic [1:0]  mtr;
      logic [5:0]  flags;   // {reg_write, mem_read, mem_write, branch, jump, illegal}
   } rec_t;

   localparam logic [5:0] F_NONE = 6'b000000;
   localparam logic [5:0] F_RW   = 6'b100000;
   localparam logic [5:0] F_MR   = 6'b010000;
   localparam logic [5:0] F_MW   = 6'b001000;
   localparam logic [5:0] F_BR   = 6'b000100;
   localparam logic [5:0] F_JP   = 6'b000010;
   localparam logic [5:0] F_IL   = 6'b000001;

   // Illegal entries only promise the side-effect flags; the ALU/imm fields
   // are left unconstrained.
   localparam rec_t M_ALL = '1;
   localparam rec_t M_ILL = '{pc: '1, imm: '0, rs1: '1, rs2: '1, rd: '1, funct3: '1,
                              alu_op: '0, alu_src: '0, mtr: '0, flags: '1};

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            out_ready;

   logic            d0_in_ready, d0_out_valid;
   logic [XLEN-1:0] d0_out_pc, d0_out_imm;
   logic [4:0]      d0_out_rs1, d0_out_rs2, d0_out_rd, d0_out_alu_op;
   logic [2:0]      d0_out_funct3;
   logic [1:0]      d0_out_alu_src, d0_out_mem_to_reg;
   logic            d0_out_reg_write, d0_out_mem_read, d0_out_mem_write;
   logic            d0_out_branch, d0_out_jump, d0_out_illegal;

   logic            d1_in_ready, d1_out_valid;
   logic [XLEN-1:0] d1_out_pc, d1_out_imm;
   logic [4:0]      d1_out_rs1, d1_out_rs2, d1_out_rd, d1_out_alu_op;
   logic [2:0]      d1_out_funct3;
   logic [1:0]      d1_out_alu_src, d1_out_mem_to_reg;
   logic            d1_out_reg_write, d1_out_mem_read, d1_out_mem_write;
   logic            d1_out_branch, d1_out_jump, d1_out_illegal;

   pipelined_decoder #(.XLEN(XLEN), .ENABLE_M(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(d0_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .flush(flush), .out_valid(d0_out_valid), .out_ready(out_ready),
      .out_pc(d0_out_pc), .out_rs1(d0_out_rs1), .out_rs2(d0_out_rs2), .out_rd(d0_out_rd),
      .out_funct3(d0_out_funct3), .out_imm(d0_out_imm), .out_alu_op(d0_out_alu_op),
      .out_alu_src(d0_out_alu_src), .out_mem_to_reg(d0_out_mem_to_reg),
      .out_reg_write(d0_out_reg_write), .out_mem_read(d0_out_mem_read),
      .out_mem_write(d0_out_mem_write), .out_branch(d0_out_branch),
      .out_jump(d0_out_jump), .out_illegal(d0_out_illegal)
   );

   pipelined_decoder #(.XLEN(XLEN), .ENABLE_M(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(d1_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .flush(flush), .out_valid(d1_out_valid), .out_ready(out_ready),
      .out_pc(d1_out_pc), .out_rs1(d1_out_rs1), .out_rs2(d1_out_rs2), .out_rd(d1_out_rd),
      .out_funct3(d1_out_funct3), .out_imm(d1_out_imm), .out_alu_op(d1_out_alu_op),
      .out_alu_src(d1_out_alu_src), .out_mem_to_reg(d1_out_mem_to_reg),
      .out_reg_write(d1_out_reg_write), .out_mem_read(d1_out_mem_read),
      .out_mem_write(d1_out_mem_write), .out_branch(d1_out_branch),
      .out_jump(d1_out_jump), .out_illegal(d1_out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   tests;
   int   fails;
   rec_t q0[$], mq0[$], q1[$], mq1[$];
   rec_t cur_e0, cur_m0, cur_e1, cur_m1;

   function automatic rec_t obs0();
      rec_t r;
      r = {d0_out_pc, d0_out_imm, d0_out_rs1, d0_out_rs2, d0_out_rd, d0_out_funct3,
           d0_out_alu_op, d0_out_alu_src, d0_out_mem_to_reg, d0_out_reg_write,
           d0_out_mem_read, d0_out_mem_write, d0_out_branch, d0_out_jump, d0_out_illegal};
      return r;
   endfunction

   function automatic rec_t obs1();
      rec_t r;
      r = {d1_out_pc, d1_out_imm, d1_out_rs1, d1_out_rs2, d1_out_rd, d1_out_funct3,
           d1_out_alu_op, d1_out_alu_src, d1_out_mem_to_reg, d1_out_reg_write,
           d1_out_mem_read, d1_out_mem_write, d1_out_branch, d1_out_jump, d1_out_illegal};
      return r;
   endfunction

   function automatic rec_t mk(logic [31:0] imm, logic [4:0] op, logic [1:0] src,
                               logic [1:0] mtr, logic [5:0] flags);
      rec_t r;
      r         = '0;
      r.imm     = imm;
      r.alu_op  = op;
      r.alu_src = src;
      r.mtr     = mtr;
      r.flags   = flags;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample both handshakes at the falling edge (the inputs were
   // driven just after the previous rising edge), then advance to 1 time unit
   // past the next rising edge.
   task automatic tick();
      rec_t e, m;
      @(negedge clk);
      if (rst || flush) begin
         q0.delete(); mq0.delete(); q1.delete(); mq1.delete();
      end else begin
         if (d0_out_valid && out_ready) begin
            if (q0.size() == 0) chk("sb0_extra", 128'(d0_out_valid), 128'(0));
            else begin
               e = q0.pop_front(); m = mq0.pop_front();
               chk("sb0", 128'(obs0() & m), 128'(e & m));
            end
         end
         if (d1_out_valid && out_ready) begin
            if (q1.size() == 0) chk("sb1_extra", 128'(d1_out_valid), 128'(0));
            else begin
               e = q1.pop_front(); m = mq1.pop_front();
               chk("sb1", 128'(obs1() & m), 128'(e & m));
            end
         end
         if (in_valid && d0_in_ready) begin q0.push_back(cur_e0); mq0.push_back(cur_m0); end
         if (in_valid && d1_in_ready) begin q1.push_back(cur_e1); mq1.push_back(cur_m1); end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                        input rec_t x0, input rec_t k0, input rec_t x1, input rec_t k1);
      x0.pc = pc; x0.rs1 = instr[19:15]; x0.rs2 = instr[24:20];
      x0.rd = instr[11:7]; x0.funct3 = instr[14:12];
      x1.pc = pc; x1.rs1 = instr[19:15]; x1.rs2 = instr[24:20];
      x1.rd = instr[11:7]; x1.funct3 = instr[14:12];
      cur_e0 = x0; cur_m0 = k0; cur_e1 = x1; cur_m1 = k1;
      in_instr = instr;
      in_pc    = pc;
      in_valid = 1'b1;
   endtask

   task automatic send(input logic [31:0] instr, input logic [31:0] pc, input rec_t x, input rec_t k);
      drive(instr, pc, x, k, x, k);
      tick();
   endtask

   task automatic drain(input string tag);
      in_valid = 1'b0;
      for (int i = 0; i < 12 && (q0.size() != 0 || q1.size() != 0); i++) tick();
      chk({tag, "_left0"}, 128'(q0.size()), 128'(0));
      chk({tag, "_left1"}, 128'(q1.size()), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      cur_e0 = '0; cur_m0 = '0; cur_e1 = '0; cur_m1 = '0;

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", 128'({d0_out_valid, d0_in_ready, d0_out_pc, d0_out_imm,
                             d0_out_alu_op, d0_out_reg_write, d0_out_illegal}), 128'(0));
      rst = 1'b0;
      #1;
      chk("ready_before_clk", 128'(d0_in_ready), 128'(0));
      @(posedge clk);
      #1;
      chk("ready_after_clk", 128'({d0_in_ready, d1_in_ready}), 128'(2'b11));

      // ---- streaming decode, one per cycle ----
      out_ready = 1'b1;
      send(32'h00500093, 32'h100, mk(32'd5, 5'b00000, 2'b01, 2'b00, F_RW), M_ALL);       // addi
      chk("latency", 128'(d0_out_valid), 128'(1));
      send(32'h402081B3, 32'h104, mk(32'd0, 5'b00001, 2'b00, 2'b00, F_RW), M_ALL);       // sub
      send(32'h00309093, 32'h108, mk(32'd3, 5'b00101, 2'b01, 2'b00, F_RW), M_ALL);       // slli 3
      send(32'hFE000EE3, 32'h10C, mk(32'hFFFFFFFC, 5'b00001, 2'b00, 2'b00, F_BR), M_ALL); // beq -4
      drive(32'h027302B3, 32'h110, mk(32'd0, 5'b0, 2'b0, 2'b0, F_IL), M_ILL,              // mul
            mk(32'd0, 5'b10000, 2'b00, 2'b00, F_RW), M_ALL);
      tick();
      send(32'h0040A103, 32'h114, mk(32'd4, 5'b00000, 2'b01, 2'b11, F_RW | F_MR), M_ALL); // lw
      send(32'h0020A423, 32'h118, mk(32'd8, 5'b00000, 2'b01, 2'b00, F_MW), M_ALL);        // sw
      send(32'h123452B7, 32'h11C, mk(32'h12345000, 5'b00000, 2'b01, 2'b00, F_RW), M_ALL); // lui
      send(32'hFFFFF317, 32'h120, mk(32'hFFFFF000, 5'b00000, 2'b01, 2'b01, F_RW), M_ALL); // auipc
      send(32'h010000EF, 32'h124, mk(32'd16, 5'b00000, 2'b01, 2'b10, F_RW | F_JP), M_ALL);// jal
      send(32'h00008067, 32'h128, mk(32'd0, 5'b00000, 2'b01, 2'b10, F_JP), M_ALL);        // jalr x0
      send(32'h00009067, 32'h12C, mk(32'd0, 5'b0, 2'b0, 2'b0, F_IL), M_ILL);              // jalr f3=1
      send(32'h4020D093, 32'h130, mk(32'h402, 5'b00111, 2'b01, 2'b00, F_RW), M_ALL);      // srai 2
      send(32'h4220D093, 32'h134, mk(32'd0, 5'b0, 2'b0, 2'b0, F_IL), M_ILL);              // bad srai
      send(32'h4020D0B3, 32'h138, mk(32'd0, 5'b00111, 2'b00, 2'b00, F_RW), M_ALL);        // sra
      send(32'h4020C0B3, 32'h13C, mk(32'd0, 5'b0, 2'b0, 2'b0, F_IL), M_ILL);              // alt xor
      send(32'h00500092, 32'h140, mk(32'd0, 5'b0, 2'b0, 2'b0, F_IL), M_ILL);              // bits[1:0]
      send(32'h0000007F, 32'h144, mk(32'd0, 5'b0, 2'b0, 2'b0, F_IL), M_ILL);              // opcode
      send(32'h00000013, 32'h148, mk(32'd0, 5'b00000, 2'b01, 2'b00, F_NONE), M_ALL);      // nop
      drain("stream");

      // ---- back-pressure: two accepted, third held off, then in-order drain ----
      out_ready = 1'b0;
      send(32'h003170B3, 32'h200, mk(32'd0, 5'b00010, 2'b00, 2'b00, F_RW), M_ALL);        // and
      send(32'h003130B3, 32'h204, mk(32'd0, 5'b01001, 2'b00, 2'b00, F_RW), M_ALL);        // sltu
      drive(32'h123452B7, 32'h208, mk(32'h12345000, 5'b00000, 2'b01, 2'b00, F_RW), M_ALL,
            mk(32'h12345000, 5'b00000, 2'b01, 2'b00, F_RW), M_ALL);                         // lui
      chk("bp_ready_low", 128'(d0_in_ready), 128'(0));
      chk("bp_accepted", 128'(q0.size()), 128'(2));
      tick();
      tick();
      chk("bp_hold", 128'({d0_out_valid, d0_out_pc, d0_out_alu_op}), 128'({1'b1, 32'h200, 5'b00010}));
      out_ready = 1'b1;
      tick();
      tick();
      drain("bp");

      // ---- flush while full, with an instruction offered ----
      out_ready = 1'b0;
      send(32'h00500093, 32'h300, mk(32'd5, 5'b00000, 2'b01, 2'b00, F_RW), M_ALL);
      send(32'h4020D0B3, 32'h304, mk(32'd0, 5'b00111, 2'b00, 2'b00, F_RW), M_ALL);
      drive(32'h00309093, 32'h308, mk(32'd3, 5'b00101, 2'b01, 2'b00, F_RW), M_ALL,
            mk(32'd3, 5'b00101, 2'b01, 2'b00, F_RW), M_ALL);
      flush = 1'b1;
      tick();
      chk("flush_full", 128'({d0_out_valid, d0_in_ready}), 128'(2'b01));
      // Flush from empty: the input is accepted by the handshake but dropped
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_drop", 128'({d0_out_valid, d1_out_valid}), 128'(2'b00));
      out_ready = 1'b1;
      send(32'h010000EF, 32'h30C, mk(32'd16, 5'b00000, 2'b01, 2'b10, F_RW | F_JP), M_ALL);
      drain("post_flush");

      // ---- asynchronous reset mid-stream ----
      out_ready = 1'b0;
      send(32'h0040A103, 32'h400, mk(32'd4, 5'b00000, 2'b01, 2'b11, F_RW | F_MR), M_ALL);
      drive(32'h00000013, 32'h404, mk(32'd0, 5'b0, 2'b01, 2'b00, F_NONE), M_ALL,
            mk(32'd0, 5'b0, 2'b01, 2'b00, F_NONE), M_ALL);
      rst = 1'b1;
      #1;
      chk("arst_async", 128'({d0_out_valid, d0_in_ready, d0_out_pc, d0_out_mem_read}), 128'(0));
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("arst_ready", 128'(d0_in_ready), 128'(1));
      out_ready = 1'b1;
      send(32'h402081B3, 32'h500, mk(32'd0, 5'b00001, 2'b00, 2'b00, F_RW), M_ALL);
      drain("post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
